// File: rtl/rstage_dispatch_pkg.sv
// rstage_dispatch_pkg: shared R-stage dispatch definitions.
// Holds the sequencing state encodings and the default field widths
// used by the dispatch register and its helpers.
package rstage_dispatch_pkg;

    localparam int DELTA_W_DEF = 4;
    localparam int LEN_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10
    } state_e;

endpackage

// File: rtl/optop_shft_gen.sv
// optop_shft_gen: sign-extend a word delta and scale it to a byte shift.
// Ports:
//   delta_i  signed optop change in words
//   shft_o   32-bit byte shift (delta * 4)
module optop_shft_gen #(
    parameter int DELTA_W = 4
) (
    input  logic [DELTA_W-1:0] delta_i,
    output logic [31:0]        shft_o
);

    assign shft_o = {{(30-DELTA_W){delta_i[DELTA_W-1]}}, delta_i, 2'b00};

endmodule

// File: rtl/rstage_dispatch.sv
// rstage_dispatch: decode-to-R-stage dispatch register of the IU.
// Ports:
//   clk, reset_l                  clock, asynchronous active-low reset
//   dec_*_d                       decoded group from the D stage
//   hold_r                        freeze R stage
//   kill_inst_d, iu_brtaken_e,
//   iu_trap_c                     squash sources
//   trap_in_progress              trap frame build owns R stage
//   dispatch_rdy_d, iu_shift_d    same-cycle accept handshake to the ibuffer
//   inst_vld_r, fold_r,
//   first_cyc_r, optop_shft_r,
//   pc_offset_r                   registered R-stage qualifiers
module rstage_dispatch
    import rstage_dispatch_pkg::*;
#(
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               dec_vld_d,
    input  logic [LEN_W-1:0]   dec_len_d,
    input  logic [DELTA_W-1:0] dec_delta_d,
    input  logic               dec_fold_d,
    input  logic               dec_two_cyc_d,
    input  logic [LEN_W-1:0]   dec_pc_off_d,
    input  logic               hold_r,
    input  logic               kill_inst_d,
    input  logic               iu_brtaken_e,
    input  logic               iu_trap_c,
    input  logic               trap_in_progress,
    output logic               dispatch_rdy_d,
    output logic [LEN_W-1:0]   iu_shift_d,
    output logic               inst_vld_r,
    output logic               fold_r,
    output logic               first_cyc_r,
    output logic [31:0]        optop_shft_r,
    output logic [LEN_W-1:0]   pc_offset_r
);

    state_e             state_q;
    logic [DELTA_W-1:0] sh_delta_q;
    logic [LEN_W-1:0]   sh_pc_q;
    logic               squash;
    logic               accept;
    logic [31:0]        live_shft;
    logic [31:0]        shadow_shft;

    optop_shft_gen #(.DELTA_W(DELTA_W)) u_live (
        .delta_i (dec_delta_d),
        .shft_o  (live_shft)
    );

    optop_shft_gen #(.DELTA_W(DELTA_W)) u_shadow (
        .delta_i (sh_delta_q),
        .shft_o  (shadow_shft)
    );

    assign squash = kill_inst_d | iu_brtaken_e | iu_trap_c;

    // reset_l gates the handshake so the ibuffer never retires bytes while in reset
    assign dispatch_rdy_d = reset_l & !hold_r & !trap_in_progress & !squash & (state_q != FIRST);
    assign accept         = dec_vld_d & dispatch_rdy_d;
    assign iu_shift_d     = accept ? dec_len_d : '0;

    // squash beats trap frame build beats hold; the second half of a
    // two-cycle op takes priority over any new group
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= IDLE;
            sh_delta_q   <= '0;
            sh_pc_q      <= '0;
            inst_vld_r   <= 1'b0;
            fold_r       <= 1'b0;
            first_cyc_r  <= 1'b0;
            optop_shft_r <= '0;
            pc_offset_r  <= '0;
        end else if (squash) begin
            state_q     <= IDLE;
            sh_delta_q  <= '0;
            sh_pc_q     <= '0;
            inst_vld_r  <= 1'b0;
            first_cyc_r <= 1'b0;
        end else if (trap_in_progress) begin
            state_q     <= IDLE;
            inst_vld_r  <= 1'b0;
            first_cyc_r <= 1'b0;
        end else if (!hold_r) begin
            if (state_q == FIRST) begin
                state_q      <= SECOND;
                inst_vld_r   <= 1'b1;
                fold_r       <= 1'b0;
                first_cyc_r  <= 1'b0;
                optop_shft_r <= shadow_shft;
                pc_offset_r  <= sh_pc_q;
            end else if (accept) begin
                state_q      <= dec_two_cyc_d ? FIRST : IDLE;
                inst_vld_r   <= 1'b1;
                fold_r       <= dec_two_cyc_d ? 1'b0 : dec_fold_d;
                first_cyc_r  <= dec_two_cyc_d;
                optop_shft_r <= dec_two_cyc_d ? '0 : live_shft;
                pc_offset_r  <= dec_pc_off_d;
                if (dec_two_cyc_d) begin
                    sh_delta_q <= dec_delta_d;
                    sh_pc_q    <= dec_pc_off_d;
                end
            end else begin
                state_q     <= IDLE;
                inst_vld_r  <= 1'b0;
                first_cyc_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rstage_dispatch.sv
// tb_rstage_dispatch: self-checking bench for rstage_dispatch.
module tb_rstage_dispatch;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        dec_vld_d = 1'b0;
    logic [2:0]  dec_len_d = '0;
    logic [3:0]  dec_delta_d = '0;
    logic        dec_fold_d = 1'b0;
    logic        dec_two_cyc_d = 1'b0;
    logic [2:0]  dec_pc_off_d = '0;
    logic        hold_r = 1'b0;
    logic        kill_inst_d = 1'b0;
    logic        iu_brtaken_e = 1'b0;
    logic        iu_trap_c = 1'b0;
    logic        trap_in_progress = 1'b0;
    logic        dispatch_rdy_d;
    logic [2:0]  iu_shift_d;
    logic        inst_vld_r;
    logic        fold_r;
    logic        first_cyc_r;
    logic [31:0] optop_shft_r;
    logic [2:0]  pc_offset_r;

    int tests = 0;
    int fails = 0;

    rstage_dispatch dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .dec_vld_d        (dec_vld_d),
        .dec_len_d        (dec_len_d),
        .dec_delta_d      (dec_delta_d),
        .dec_fold_d       (dec_fold_d),
        .dec_two_cyc_d    (dec_two_cyc_d),
        .dec_pc_off_d     (dec_pc_off_d),
        .hold_r           (hold_r),
        .kill_inst_d      (kill_inst_d),
        .iu_brtaken_e     (iu_brtaken_e),
        .iu_trap_c        (iu_trap_c),
        .trap_in_progress (trap_in_progress),
        .dispatch_rdy_d   (dispatch_rdy_d),
        .iu_shift_d       (iu_shift_d),
        .inst_vld_r       (inst_vld_r),
        .fold_r           (fold_r),
        .first_cyc_r      (first_cyc_r),
        .optop_shft_r     (optop_shft_r),
        .pc_offset_r      (pc_offset_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  len;
        logic [3:0]  delta;
        logic        fold;
        logic        two;
        logic [2:0]  pc;
        logic        hold;
        logic        kill;
        logic        br;
        logic        trapc;
        logic        tip;
        logic        rdy;
        logic [2:0]  sh;
        logic        evld;
        logic        efold;
        logic        efirst;
        logic [31:0] eopt;
        logic [2:0]  epc;
        logic [2:0]  msk;
    } vec_t;

    typedef struct {
        logic        evld;
        logic        efold;
        logic        efirst;
        logic [31:0] eopt;
        logic [2:0]  epc;
        logic [2:0]  msk;
    } exp_t;

    vec_t tbl[22];
    exp_t exp_q[$];

    function automatic vec_t mk(
        logic vld, logic [2:0] len, logic [3:0] delta, logic fold, logic two, logic [2:0] pc,
        logic hold, logic kill, logic br, logic trapc, logic tip,
        logic rdy, logic [2:0] sh,
        logic evld, logic efold, logic efirst, logic [31:0] eopt, logic [2:0] epc, logic [2:0] msk);
        vec_t v;
        v.vld = vld; v.len = len; v.delta = delta; v.fold = fold; v.two = two; v.pc = pc;
        v.hold = hold; v.kill = kill; v.br = br; v.trapc = trapc; v.tip = tip;
        v.rdy = rdy; v.sh = sh;
        v.evld = evld; v.efold = efold; v.efirst = efirst; v.eopt = eopt; v.epc = epc; v.msk = msk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dec_vld_d = v.vld; dec_len_d = v.len; dec_delta_d = v.delta; dec_fold_d = v.fold;
        dec_two_cyc_d = v.two; dec_pc_off_d = v.pc; hold_r = v.hold; kill_inst_d = v.kill;
        iu_brtaken_e = v.br; iu_trap_c = v.trapc; trap_in_progress = v.tip;
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        // vld len delta fold two pc | hold kill br trapc tip | rdy sh | vld fold first optop pc msk{fold,optop,pc}
        tbl[0]  = mk(0,0,4'h0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,32'h0,0,3'b000);
        tbl[1]  = mk(1,3,4'hE,1,0,2, 0,0,0,0,0, 1,3, 1,1,0,32'hFFFFFFF8,2,3'b111);
        tbl[2]  = mk(1,2,4'h1,0,1,5, 0,0,0,0,0, 1,2, 1,0,1,32'h0,0,3'b110);
        tbl[3]  = mk(1,1,4'h3,0,0,0, 0,0,0,0,0, 0,0, 1,0,0,32'h4,5,3'b111);
        tbl[4]  = mk(1,4,4'h7,0,0,1, 0,0,0,0,0, 1,4, 1,0,0,32'h1C,1,3'b111);
        tbl[5]  = mk(0,0,4'h0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,32'h0,0,3'b000);
        tbl[6]  = mk(1,1,4'hF,0,0,0, 0,0,0,0,0, 1,1, 1,0,0,32'hFFFFFFFC,0,3'b111);
        tbl[7]  = mk(1,5,4'h2,1,0,3, 1,0,0,0,0, 0,0, 1,0,0,32'hFFFFFFFC,0,3'b111);
        tbl[8]  = mk(1,5,4'h2,1,0,3, 1,0,0,0,0, 0,0, 1,0,0,32'hFFFFFFFC,0,3'b111);
        tbl[9]  = mk(1,5,4'h2,1,0,3, 1,0,0,0,0, 0,0, 1,0,0,32'hFFFFFFFC,0,3'b111);
        tbl[10] = mk(1,5,4'h2,1,0,3, 0,0,0,0,0, 1,5, 1,1,0,32'h8,3,3'b111);
        tbl[11] = mk(1,2,4'h6,0,1,4, 0,0,0,0,0, 1,2, 1,0,1,32'h0,0,3'b110);
        tbl[12] = mk(0,0,4'h0,0,0,0, 1,0,0,0,0, 0,0, 1,0,1,32'h0,0,3'b110);
        tbl[13] = mk(1,3,4'h1,0,0,0, 1,0,1,0,0, 0,0, 0,0,0,32'h0,0,3'b000);
        tbl[14] = mk(0,0,4'h0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,32'h0,0,3'b000);
        tbl[15] = mk(1,3,4'h1,0,0,0, 0,1,0,0,0, 0,0, 0,0,0,32'h0,0,3'b000);
        tbl[16] = mk(1,3,4'h1,0,0,1, 0,0,0,0,1, 0,0, 0,0,0,32'h0,0,3'b000);
        tbl[17] = mk(1,3,4'h1,0,0,1, 0,0,0,0,1, 0,0, 0,0,0,32'h0,0,3'b000);
        tbl[18] = mk(1,3,4'h1,0,0,1, 0,0,0,0,0, 1,3, 1,0,0,32'h4,1,3'b111);
        tbl[19] = mk(1,1,4'h5,0,1,0, 0,0,0,0,0, 1,1, 1,0,1,32'h0,0,3'b110);
        tbl[20] = mk(0,0,4'h0,0,0,0, 0,0,0,1,0, 0,0, 0,0,0,32'h0,0,3'b000);
        tbl[21] = mk(0,0,4'h0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,32'h0,0,3'b000);
        idle = tbl[0];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(inst_vld_r), 0);
        chk("rst_first", 32'(first_cyc_r), 0);
        chk("rst_fold", 32'(fold_r), 0);
        chk("rst_optop", optop_shft_r, 0);
        chk("rst_pc", 32'(pc_offset_r), 0);
        chk("rst_shift", 32'(iu_shift_d), 0);
        reset_l = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(dispatch_rdy_d), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_shift", i), 32'(iu_shift_d), 32'(tbl[i].sh));
            e.evld = tbl[i].evld; e.efold = tbl[i].efold; e.efirst = tbl[i].efirst;
            e.eopt = tbl[i].eopt; e.epc = tbl[i].epc; e.msk = tbl[i].msk;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d_vld", i), 32'(inst_vld_r), 32'(e.evld));
                chk($sformatf("v%0d_first", i), 32'(first_cyc_r), 32'(e.efirst));
                if (e.msk[2]) chk($sformatf("v%0d_fold", i), 32'(fold_r), 32'(e.efold));
                if (e.msk[1]) chk($sformatf("v%0d_optop", i), optop_shft_r, e.eopt);
                if (e.msk[0]) chk($sformatf("v%0d_pc", i), 32'(pc_offset_r), 32'(e.epc));
            end
        end

        // asynchronous reset in the middle of a two-cycle op
        drive(mk(1,2,4'h3,0,1,1, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("pre_rst_first", 32'(first_cyc_r), 1);
        chk("pre_rst_vld", 32'(inst_vld_r), 1);
        #2;
        reset_l = 1'b0;
        #1;
        chk("arst_vld", 32'(inst_vld_r), 0);
        chk("arst_first", 32'(first_cyc_r), 0);
        chk("arst_fold", 32'(fold_r), 0);
        chk("arst_optop", optop_shft_r, 0);
        chk("arst_pc", 32'(pc_offset_r), 0);
        chk("arst_rdy", 32'(dispatch_rdy_d), 0);
        chk("arst_shift", 32'(iu_shift_d), 0);
        @(posedge clk);
        #1;
        drive(idle);
        #2;
        reset_l = 1'b1;
        #1;
        chk("rel_shift", 32'(iu_shift_d), 0);
        chk("rel_vld", 32'(inst_vld_r), 0);
        drive(mk(1,1,4'h8,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        #1;
        chk("rel_acc_shift", 32'(iu_shift_d), 1);
        @(posedge clk);
        #1;
        drive(idle);
        chk("rel_vld_next", 32'(inst_vld_r), 1);
        chk("rel_first_next", 32'(first_cyc_r), 0);
        chk("rel_optop_m8", optop_shft_r, 32'hFFFFFFE0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
